// File: rtl/input_device_bank_if.sv
// Read-port bundle for input_device_bank: address/strobe in, registered data out.
interface input_device_bank_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read_en;
  logic [WIDTH-1:0]      value;
  logic                  value_valid;
  logic                  addr_err;

  modport master (
    output address, read_en,
    input  value, value_valid, addr_err
  );

  modport slave (
    input  address, read_en,
    output value, value_valid, addr_err
  );
endinterface

// File: rtl/input_device_bank.sv
// Synchronised input-device bank with sticky change flags,
// a registered address-selected read port and an interrupt line.
module input_device_bank #(
  parameter int                    NUM_DEVICES = 4,
  parameter int                    WIDTH       = 32,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 16'h00FF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_DEVICES*WIDTH-1:0] device_values,
  input_device_bank_if.slave           bus,
  output logic [NUM_DEVICES-1:0]       changed,
  output logic                         irq
);

  localparam int DW   = NUM_DEVICES * WIDTH;
  localparam int IDXW = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int SW   = (NUM_DEVICES < WIDTH) ? NUM_DEVICES : WIDTH;

  logic [DW-1:0]          r_sync [SYNC_STAGES];
  logic [DW-1:0]          r_prev;
  logic [NUM_DEVICES-1:0] r_changed;
  logic [WIDTH-1:0]       r_value;
  logic                   r_valid;
  logic                   r_err;

  logic [WIDTH-1:0]       w_words [NUM_DEVICES];
  logic [NUM_DEVICES-1:0] w_set;
  logic [NUM_DEVICES-1:0] w_clr;
  logic [WIDTH-1:0]       w_status;
  logic [IDXW-1:0]        w_idx;
  logic                   w_is_dev;
  logic                   w_is_stat;

  for (genvar d = 0; d < NUM_DEVICES; d++) begin : g_dev
    assign w_words[d] = r_sync[SYNC_STAGES-1][d*WIDTH +: WIDTH];
    assign w_set[d]   = w_words[d] != r_prev[d*WIDTH +: WIDTH];
  end

  assign w_idx     = bus.address[IDXW-1:0];
  assign w_is_dev  = bus.address < ADDR_WIDTH'(NUM_DEVICES);
  assign w_is_stat = bus.address == STATUS_ADDR;

  always_comb begin
    w_status         = '0;
    w_status[SW-1:0] = r_changed[SW-1:0];
  end

  always_comb begin
    w_clr = '0;
    if (bus.read_en && w_is_dev)
      w_clr[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      r_sync[0] <= device_values;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  // A new change on the same edge as a read-clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_changed <= '0;
    end else begin
      r_prev    <= r_sync[SYNC_STAGES-1];
      r_changed <= (r_changed & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.read_en) begin
      r_valid <= 1'b1;
      unique case (1'b1)
        w_is_dev: begin
          r_value <= w_words[w_idx];
          r_err   <= 1'b0;
        end
        w_is_stat: begin
          r_value <= w_status;
          r_err   <= 1'b0;
        end
        default: begin
          r_value <= '0;
          r_err   <= 1'b1;
        end
      endcase
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign bus.value       = r_value;
  assign bus.value_valid = r_valid;
  assign bus.addr_err    = r_err;
  assign changed         = r_changed;
  assign irq             = |r_changed;

endmodule

// File: tb/tb_input_device_bank.sv
// Bench for input_device_bank: delay-line reference model,
// per-cycle compare process and literal anchor checks.
module tb_input_device_bank;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] device_values;
  logic [N-1:0]  changed;
  logic          irq;

  input_device_bank_if #(.WIDTH(W), .ADDR_WIDTH(16)) bus ();

  input_device_bank dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .device_values (device_values),
    .bus           (bus),
    .changed       (changed),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // hist[0] = input seen S+1 edges ago, hist[S] = input seen last edge
  logic [DW-1:0] hist [S+1];
  logic [N-1:0]  m_changed;
  logic [W-1:0]  m_value;
  logic          m_vv;
  logic          m_err;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= S; i++) hist[i] = '0;
    m_changed = '0;
    m_value   = '0;
    m_vv      = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] set_v;
    logic [N-1:0] clr_v;
    int           a;
    set_v = '0;
    clr_v = '0;
    a     = int'(bus.address);
    for (int d = 0; d < N; d++)
      set_v[d] = hist[S-1][d*W +: W] != hist[S-2][d*W +: W];
    if (bus.read_en) begin
      m_vv = 1'b1;
      if (a < N) begin
        m_value  = hist[S-1][a*W +: W];
        clr_v[a] = 1'b1;
        m_err    = 1'b0;
      end else if (a == 'h00FF) begin
        m_value = W'(m_changed);
        m_err   = 1'b0;
      end else begin
        m_value = '0;
        m_err   = 1'b1;
      end
    end else begin
      m_vv  = 1'b0;
      m_err = 1'b0;
    end
    m_changed = (m_changed & ~clr_v) | set_v;
    for (int i = 0; i < S; i++) hist[i] = hist[i+1];
    hist[S] = device_values;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("value", bus.value, m_value);
      chk("value_valid", bus.value_valid, m_vv);
      chk("addr_err", bus.addr_err, m_err);
      chk("changed", changed, m_changed);
      chk("irq", irq, |m_changed);
    end
  end

  task automatic tick(input logic rd, input logic [15:0] a);
    bus.read_en = rd;
    bus.address = a;
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic set_dev(input int d, input logic [W-1:0] v);
    device_values[d*W +: W] = v;
  endtask

  logic [W-1:0]  cur;
  logic [W-1:0]  nxt;
  logic [15:0]   addr;
  int            sel;

  initial begin
    reset_n       = 1'b0;
    bus.read_en   = 1'b0;
    bus.address   = '0;
    device_values = '0;
    set_dev(0, 32'hE5F84AB1);
    set_dev(1, 32'h5C8C6A01);
    model_reset();
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    tick(0, 0);
    tick(0, 0);
    chk("changed_pre", changed, 4'b0000);
    tick(0, 0);
    chk("changed_init", changed, 4'b0011);
    chk("irq_init", irq, 1'b1);
    tick(1, 0);
    chk("rd0_value", bus.value, 32'hE5F84AB1);
    chk("rd0_valid", bus.value_valid, 1'b1);
    tick(0, 0);
    chk("rd0_valid_drop", bus.value_valid, 1'b0);
    chk("rd0_clear", changed, 4'b0010);
    tick(1, 1);
    chk("rd1_value", bus.value, 32'h5C8C6A01);
    tick(1, 16'h00FF);
    chk("stat_value", bus.value, 32'h0);
    chk("stat_valid", bus.value_valid, 1'b1);
    chk("stat_changed", changed, 4'b0000);
    chk("stat_irq", irq, 1'b0);
    tick(0, 0);

    set_dev(2, 32'h00000001);
    tick(1, 2);
    chk("rd2_early", bus.value, 32'h0);
    tick(0, 0);
    chk("dev2_k2", changed[2], 1'b0);
    tick(0, 0);
    chk("dev2_k3", changed[2], 1'b1);
    tick(1, 2);
    chk("rd2_late", bus.value, 32'h1);

    set_dev(3, 32'hA5A50003);
    tick(0, 0);
    tick(0, 0);
    tick(1, 3);
    chk("dev3_setwins", changed[3], 1'b1);
    chk("dev3_valid", bus.value_valid, 1'b1);

    tick(1, 4);
    chk("err4_value", bus.value, 32'h0);
    chk("err4_flag", bus.addr_err, 1'b1);
    tick(1, 16'h1234);
    chk("err1234_flag", bus.addr_err, 1'b1);
    chk("err1234_valid", bus.value_valid, 1'b1);
    tick(0, 0);
    chk("err_idle", bus.addr_err, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_dev(int'($urandom_range(0, N-1)), $urandom);
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1, 2, 3: addr = 16'(sel);
        4:          addr = 16'h00FF;
        5:          addr = 16'h0004;
        6:          addr = 16'h1234;
        default:    addr = 16'($urandom_range(0, 65535));
      endcase
      tick(1'($urandom_range(0, 1)), addr);
    end

    for (int d = 0; d < N; d++) begin
      cur = device_values[d*W +: W];
      nxt = {cur[W-1:1], ~cur[0]};
      if (nxt == '0) nxt = 32'h2;
      set_dev(d, nxt);
    end
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    tick(1, 16'h00FF);
    chk("pre_rst_changed", changed, 4'b1111);
    chk("pre_rst_valid", bus.value_valid, 1'b1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_value", bus.value, 32'h0);
    chk("rst_valid", bus.value_valid, 1'b0);
    chk("rst_err", bus.addr_err, 1'b0);
    chk("rst_changed", changed, 4'b0000);
    chk("rst_irq", irq, 1'b0);
    tick(0, 0);
    tick(0, 0);
    @(negedge clk) reset_n = 1'b1;
    tick(0, 0);
    tick(0, 0);
    chk("rerst_pre", changed, 4'b0000);
    tick(0, 0);
    chk("rerst_flags", changed, 4'b1111);
    tick(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
